cc_stack_unit: RTL
==================

# cc_stack_unit

Parametrised condition-code unit for the datapath: classifies the value on the bus into N/Z/P and registers it, with a hardware save/restore stack of depth DEPTH for interrupt entry and return. It also produces the registered branch-enable (BEN) bit from the instruction's n/z/p mask. It is a drop-in successor to the single-register condition-code block and sits between the bus and the control FSM.

## Interface
- WIDTH, 16, bus width in bits (≥2); two's-complement data
- DEPTH, 4, save-stack entries (≥1)
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- Load  in  1  capture the classification of BUS into the CC register
- BUS  in  WIDTH  value to classify
- Push  in  1  save the current CC onto the stack
- Pop  in  1  restore the CC from the stack top
- LD_BEN  in  1  register the branch-enable result
- IR_nzp  in  3  branch mask {n,z,p}
- Nout, Zout, Pout  out  1 each  registered condition codes
- BEN  out  1  registered branch enable
- Depth  out  $clog2(DEPTH+1)  number of occupied stack entries
- Full, Empty  out  1 each  stack status, combinational from Depth
- Err  out  1  stack misuse indicator

## Operation
- Classification: BUS[WIDTH-1]=1 → N=1. BUS all zero → Z=1. Otherwise P=1. Exactly one of the three is set after any Load.
- CC update priority within a cycle: Pop (valid) > Load > hold.
- Push (not full, Pop=0): stack[Depth] ← CC register value at the start of the cycle; Depth+1. A Load in the same cycle still updates the CC, and the old value is the one saved.
- Pop (not empty, Push=0): CC ← stack top; Depth−1; Load in the same cycle is ignored.
- Push and Pop in the same cycle: illegal. Stack and Depth are unchanged, the CC follows Load/hold, and an error event is raised.
- Push when Full: the entry is discarded and Depth is unchanged; error event. Pop when Empty: CC follows Load/hold; error event.
- LD_BEN: BEN ← |(IR_nzp & {Nout,Zout,Pout}), using the CC register value at the start of the cycle, not the value being loaded. When LD_BEN=0, BEN holds.
- Stack storage is not cleared on pop. Only Depth is authoritative.

## Timing
- All outputs are registered except Full/Empty, which decode Depth. Latency is 1 cycle from the strobe to the output.
- Load at edge k → Nout/Zout/Pout valid after edge k. A Load followed by LD_BEN on the next cycle sees the new CC.
- Reset, asynchronous and taking effect immediately regardless of Clk: Nout=Zout=Pout=0, BEN=0, Depth=0, Empty=1, Full=0, Err=0. Reset asserted mid-sequence drops all saved entries.
- Until the first Load or Pop after reset, CC is 000 and any BEN evaluation yields 0.
- Depth saturates at DEPTH and at 0. There is no wrap-around.

## Configuration
- CC_STICKY_ERR_EN defined: Err is sticky. It sets on the first error event and stays 1 until Reset.
- CC_STICKY_ERR_EN undefined: Err is a one-cycle pulse, high for the cycle after each error event and low otherwise.
- The macro has no other effect on behaviour.

## Test plan
- Reset, then Load with BUS=16'h8000, 16'h0000, 16'h0001 on consecutive cycles → NZP = 100, 010, 001 on successive cycles; Reset mid-stream → 000 immediately, without waiting for a clock edge.
- Load 16'hFFFF, Push with Load 16'h0005 in the same cycle, then Pop → CC=001 after the Push/Load cycle and 100 after the Pop; Depth goes 1→0.
- DEPTH=4: five Pushes → Depth=4 and Full=1 after the fourth; the fifth raises Err and Depth stays 4. Five Pops → the saved CCs return in LIFO order, and the fifth Pop raises Err with Empty=1.
- CC=010 with IR_nzp=3'b010 and LD_BEN → BEN=1. With IR_nzp=3'b101 → BEN=0. Load 16'h0003 and LD_BEN=1 with IR_nzp=3'b001 in the same cycle → BEN=0, because the pre-load CC is used.
- Push and Pop together at Depth=2 → Depth stays 2, stack contents are unchanged, and Err is raised. Check the sticky versus pulse behaviour with and without CC_STICKY_ERR_EN.
- WIDTH=8 build: BUS=8'h80 → N. BUS=8'h7F → P. BUS=8'h00 → Z.

Source files
------------

// File: rtl/cc_stack_unit_if.sv
// cc_stack_unit_if
//   Bundles the datapath-facing strobes, bus value and status outputs of
//   cc_stack_unit. The clock and reset are plain ports on the module and are
//   not part of this interface.
//
//   Parameters: WIDTH (bus width), DEPTH (save-stack entries).
//   master : drives Load/BUS/Push/Pop/LD_BEN/IR_nzp and observes the status
//            outputs (the control FSM side).
//   slave  : the condition-code unit itself.
interface cc_stack_unit_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    localparam int DW = $clog2(DEPTH + 1);

    logic             Load;
    logic [WIDTH-1:0] BUS;
    logic             Push;
    logic             Pop;
    logic             LD_BEN;
    logic [2:0]       IR_nzp;
    logic             Nout;
    logic             Zout;
    logic             Pout;
    logic             BEN;
    logic [DW-1:0]    Depth;
    logic             Full;
    logic             Empty;
    logic             Err;

    modport master (
        output Load, BUS, Push, Pop, LD_BEN, IR_nzp,
        input  Nout, Zout, Pout, BEN, Depth, Full, Empty, Err
    );

    modport slave (
        input  Load, BUS, Push, Pop, LD_BEN, IR_nzp,
        output Nout, Zout, Pout, BEN, Depth, Full, Empty, Err
    );
endinterface

// File: rtl/cc_stack_unit.sv
// cc_stack_unit
//   Condition-code unit: classifies BUS into N/Z/P on Load, keeps a
//   DEPTH-entry save/restore stack of the CC for interrupt entry/return, and
//   registers the branch-enable bit from the instruction's n/z/p mask.
//
//   Ports:
//     Clk    rising-edge clock
//     Reset  asynchronous, active-high reset
//     cc     cc_stack_unit_if.slave
//              in : Load, BUS[WIDTH], Push, Pop, LD_BEN, IR_nzp[3]
//              out: Nout/Zout/Pout, BEN, Depth, Full, Empty, Err
//
//   Configuration macro: CC_STICKY_ERR_EN
//     defined   -> Err latches on the first stack misuse until Reset
//     undefined -> Err pulses for one cycle after each misuse
module cc_stack_unit #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic            Clk,
    input  logic            Reset,
    cc_stack_unit_if.slave  cc
);
    localparam int DW = $clog2(DEPTH + 1);

    logic [2:0]    cc_q, cc_d;       // {N,Z,P}
    logic [2:0]    cls;
    logic [2:0]    top;
    logic [2:0]    stk [DEPTH];
    logic [DW-1:0] depth_q, depth_d;
    logic          ben_q, err_q;
    logic          full, empty;
    logic          push_ok, pop_ok, err_evt;

    assign full  = (depth_q == DW'(DEPTH));
    assign empty = (depth_q == '0);

    // A push or pop only acts when it is alone and the stack allows it.
    assign push_ok = cc.Push & ~cc.Pop & ~full;
    assign pop_ok  = cc.Pop  & ~cc.Push & ~empty;
    assign err_evt = (cc.Push & cc.Pop)
                   | (cc.Push & ~cc.Pop & full)
                   | (cc.Pop  & ~cc.Push & empty);

    // Sign bit wins, so a negative value never reports Z or P.
    always_comb begin
        cls = 3'b001;
        if (cc.BUS[WIDTH-1])
            cls = 3'b100;
        else if (cc.BUS == '0)
            cls = 3'b010;
    end

    // Top-of-stack is entry Depth-1; decoded by compare so the index never
    // exceeds the array bounds.
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++)
            if (depth_q == DW'(i + 1))
                top = stk[i];
    end

    always_comb begin
        cc_d    = cc_q;
        depth_d = depth_q;
        if (pop_ok) begin
            cc_d    = top;
            depth_d = depth_q - DW'(1);
        end else if (cc.Load) begin
            cc_d = cls;
        end
        if (push_ok)
            depth_d = depth_q + DW'(1);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cc_q    <= '0;
            depth_q <= '0;
            ben_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cc_q    <= cc_d;
            depth_q <= depth_d;
            // BEN looks at the CC held before this edge, not the one loading.
            if (cc.LD_BEN)
                ben_q <= |(cc.IR_nzp & cc_q);
`ifdef CC_STICKY_ERR_EN
            err_q <= err_q | err_evt;
`else
            err_q <= err_evt;
`endif
        end
    end

    // Storage is not cleared by reset or pop; Depth alone says what is valid.
    // The saved value is the CC before any same-cycle Load.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < DEPTH; i++)
            if (push_ok && depth_q == DW'(i))
                stk[i] <= cc_q;
    end

    assign cc.Nout  = cc_q[2];
    assign cc.Zout  = cc_q[1];
    assign cc.Pout  = cc_q[0];
    assign cc.BEN   = ben_q;
    assign cc.Depth = depth_q;
    assign cc.Full  = full;
    assign cc.Empty = empty;
    assign cc.Err   = err_q;
endmodule
